// File: rtl/adder4_seq_ctrl.sv
// Sequential WIDTH-bit adder built around one shared 4-bit ripple slice, one nibble per cycle.
// Optional macro ADDSEQ_SUB_EN adds a SUB input that turns the operation into A-B.

module ADDER4_2 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] S,
  output logic       Cout
);

  logic [4:0] carry;

  always_comb begin
    carry    = '0;
    S        = '0;
    carry[0] = Cin;
    for (int i = 0; i < 4; i++) begin
      S[i]         = A[i] ^ B[i] ^ carry[i];
      carry[i + 1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
    end
    Cout = carry[4];
  end

endmodule

module adder4_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
`ifdef ADDSEQ_SUB_EN
  input  logic             SUB,
`endif
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             BUSY
);

  localparam int NSLICE = WIDTH / 4;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] aReg_q;
  logic [WIDTH-1:0] bReg_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             cout_q;
  logic             outValid_q;
  logic             busy_q;
  logic             inReady_q;

  logic [WIDTH-1:0] bCapture_d;
  logic             carryInit_d;
  logic [3:0]       sliceA;
  logic [3:0]       sliceB;
  logic [3:0]       sliceS;
  logic             sliceCout;
  logic             lastSlice;

  // Subtraction is A + ~B + 1, so it reuses the same slice with a forced carry-in.
  always_comb begin
    bCapture_d  = B;
    carryInit_d = CIN;
`ifdef ADDSEQ_SUB_EN
    if (SUB) begin
      bCapture_d  = ~B;
      carryInit_d = 1'b1;
    end
`endif
  end

  always_comb begin
    sliceA = '0;
    sliceB = '0;
    for (int k = 0; k < NSLICE; k++) begin
      if (int'(cnt_q) == k) begin
        sliceA = aReg_q[4*k +: 4];
        sliceB = bReg_q[4*k +: 4];
      end
    end
    lastSlice = (int'(cnt_q) == NSLICE - 1);
  end

  ADDER4_2 u_slice (
    .A   (sliceA),
    .B   (sliceB),
    .Cin (carry_q),
    .S   (sliceS),
    .Cout(sliceCout)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      aReg_q     <= '0;
      bReg_q     <= '0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      cout_q     <= 1'b0;
      outValid_q <= 1'b0;
      busy_q     <= 1'b0;
      inReady_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (IN_VALID && inReady_q) begin
            aReg_q    <= A;
            bReg_q    <= bCapture_d;
            carry_q   <= carryInit_d;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            inReady_q <= 1'b0;
            state_q   <= RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < NSLICE; k++) begin
            if (int'(cnt_q) == k) begin
              sum_q[4*k +: 4] <= sliceS;
            end
          end
          carry_q <= sliceCout;
          if (lastSlice) begin
            cnt_q      <= '0;
            cout_q     <= sliceCout;
            outValid_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          // Result stays put until the consumer takes it.
          if (OUT_READY) begin
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: begin
          outValid_q <= 1'b0;
          busy_q     <= 1'b0;
          inReady_q  <= 1'b1;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign IN_READY  = inReady_q;
  assign OUT_VALID = outValid_q;
  assign SUM       = sum_q;
  assign COUT      = cout_q;
  assign BUSY      = busy_q;

endmodule
